// File: rtl/trace_pkg.sv
// Shared types and helpers for the result-bus trace buffer.
// Contents: capture FSM state enum, default widths, pointer-width helper.
package trace_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_DEPTH  = 16;
    localparam int unsigned DEFAULT_TS_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FROZEN  = 2'd2
    } trace_state_e;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Result-bus capture and host read port of the trace buffer.
//   res_valid/res_data : datapath result bus (into the buffer)
//   rd_ready           : host accepts the head entry (into the buffer)
//   rd_valid/rd_data   : head entry presented to the host (out of the buffer)
//   rd_ts              : head entry timestamp, zero unless WB_TRACE_TS_EN
// modport master: datapath/host side; modport slave: trace buffer side.
interface wb_trace_buffer_if
    import trace_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned TS_W   = DEFAULT_TS_W
);

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [TS_W-1:0]   rd_ts;

    modport master (
        output res_valid, res_data, rd_ready,
        input  rd_valid, rd_data, rd_ts
    );

    modport slave (
        input  res_valid, res_data, rd_ready,
        output rd_valid, rd_data, rd_ts
    );

endinterface

// File: rtl/trace_fifo_mem.sv
// FIFO storage for the trace buffer with a registered head entry.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   push, pop   : write wr_data / retire head (caller guarantees legality)
//   wr_data     : entry to store
//   head        : registered head entry, stable until popped
//   head_valid  : registered, 1 when count != 0
//   count       : entries held, 0..DEPTH
module trace_fifo_mem
    import trace_pkg::*;
#(
    parameter  int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter  int unsigned ENTRY_W = DEFAULT_DATA_W,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic [ENTRY_W-1:0] head,
    output logic               head_valid,
    output logic [CNT_W-1:0]   count
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_inc;
    logic [CNT_W-1:0]   count_nxt;
    logic [ENTRY_W-1:0] head_nxt;

    // Power-of-two depth: pointers wrap naturally.
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Next count and next head entry.
    always_comb begin
        count_nxt = count;
        head_nxt  = head;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_nxt = count - CNT_W'(1);
        end
        // The pushed word becomes head when it lands in an empty (or emptying) FIFO,
        // since it is not yet in the array when the head is reloaded.
        if (push && ((count == CNT_W'(0)) || ((count == CNT_W'(1)) && pop))) begin
            head_nxt = wr_data;
        end else if (pop && (count > CNT_W'(1))) begin
            head_nxt = mem[rd_ptr_inc];
        end
    end

    // Pointers, count and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count      <= count_nxt;
            head       <= head_nxt;
            head_valid <= (count_nxt != CNT_W'(0));
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Hardware trace of the datapath result bus: valid results are captured into a
// FIFO while armed and drained by the host over a valid/ready port.
// Optional feature macro: WB_TRACE_TS_EN (store a free-running timestamp per entry).
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   arm, disarm   : enter CAPTURE (clears overflow and timestamp) / return to IDLE
//   stop_on_full  : 1 freezes capture when a push finds the FIFO full
//   bus           : result bus and host read port (wb_trace_buffer_if.slave)
//   count         : entries held, 0..DEPTH
//   overflow      : sticky, a valid result was dropped
//   busy          : 1 while in CAPTURE
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter  int unsigned DATA_W = DEFAULT_DATA_W,
    parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter  int unsigned TS_W   = DEFAULT_TS_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               disarm,
    input  logic               stop_on_full,
    wb_trace_buffer_if.slave   bus,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic               busy
);

`ifdef WB_TRACE_TS_EN
    localparam int unsigned ENTRY_W = TS_W + DATA_W;
`else
    localparam int unsigned ENTRY_W = DATA_W;
`endif

    trace_state_e       state;
    trace_state_e       state_nxt;
    logic               overflow_nxt;
    logic               head_valid;
    logic               full;
    logic               pop;
    logic               attempt;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;

    // Push/drop decision: a full FIFO still accepts when the head leaves this cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = head_valid & bus.rd_ready;
    assign attempt = (state == CAPTURE) & bus.res_valid;
    assign push    = attempt & (~full | pop);
    assign drop    = attempt & full & ~pop;

    // Next state and overflow; disarm has the final say.
    always_comb begin
        state_nxt    = state;
        overflow_nxt = overflow;
        if (arm) begin
            overflow_nxt = 1'b0;
        end
        if (drop) begin
            overflow_nxt = 1'b1;
        end
        case (state)
            IDLE:    if (arm) state_nxt = CAPTURE;
            CAPTURE: if (drop && stop_on_full) state_nxt = FROZEN;
            FROZEN:  if (arm) state_nxt = CAPTURE;
            default: state_nxt = IDLE;
        endcase
        if (disarm) begin
            state_nxt = IDLE;
        end
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            overflow <= overflow_nxt;
            busy     <= (state_nxt == CAPTURE);
        end
    end

`ifdef WB_TRACE_TS_EN
    logic [TS_W-1:0] ts;

    // Free-running timestamp, restarted by arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else if (arm) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    assign wr_entry    = {ts, bus.res_data};
    assign bus.rd_data = head[DATA_W-1:0];
    assign bus.rd_ts   = head[ENTRY_W-1:DATA_W];
`else
    assign wr_entry    = bus.res_data;
    assign bus.rd_data = head;
    assign bus.rd_ts   = TS_W'(0);
`endif

    assign bus.rd_valid = head_valid;

    trace_fifo_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .wr_data    (wr_entry),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH=16, DATA_W=32).
module tb_wb_trace_buffer;

    logic       clk;
    logic       rst_n;
    logic       arm;
    logic       disarm;
    logic       stop_on_full;
    logic [4:0] count;
    logic       overflow;
    logic       busy;

    int tests;
    int failed;

    wb_trace_buffer_if #(.DATA_W(32), .TS_W(16)) bus ();

    wb_trace_buffer #(.DATA_W(32), .DEPTH(16), .TS_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .disarm       (disarm),
        .stop_on_full (stop_on_full),
        .bus          (bus.slave),
        .count        (count),
        .overflow     (overflow),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (count !== 5'd0) begin failed++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++;
        if (bus.rd_valid !== 1'b0) begin failed++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        tests++;
        if (bus.rd_data !== 32'h0) begin failed++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
        tests++;
        if (bus.rd_ts !== 16'h0) begin failed++; $display("FAIL reset_rd_ts: got %h want 0", bus.rd_ts); end
        tests++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            failed++; $display("FAIL reset_flags: got ovf=%b busy=%b want 0 0", overflow, busy);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_words [3];
        exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
        stop_on_full = 1'b0;
        pulse_arm();
        tests++;
        if (busy !== 1'b1) begin failed++; $display("FAIL basic_busy: got %b want 1", busy); end
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h11;
        tick();
        tests++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h11) begin
            failed++; $display("FAIL basic_latency: got v=%b d=%h want v=1 d=11", bus.rd_valid, bus.rd_data);
        end
        bus.res_data = 32'h22;
        tick();
        bus.res_data = 32'h33;
        tick();
        bus.res_valid = 1'b0;
        tick();
        tests++;
        if (count !== 5'd3 || bus.rd_data !== 32'h11) begin
            failed++; $display("FAIL basic_hold: got count=%0d d=%h want 3 11", count, bus.rd_data);
        end
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_words[i]) begin
                failed++; $display("FAIL basic_drain%0d: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp_words[i]);
            end
            tick();
        end
        bus.rd_ready = 1'b0;
        tests++;
        if (count !== 5'd0 || bus.rd_valid !== 1'b0) begin
            failed++; $display("FAIL basic_empty: got count=%0d v=%b want 0 0", count, bus.rd_valid);
        end
        pulse_disarm();
        // disarm wins over arm when both are high
        arm = 1'b1; disarm = 1'b1;
        tick();
        arm = 1'b0; disarm = 1'b0;
        tests++;
        if (busy !== 1'b0) begin failed++; $display("FAIL disarm_priority: got busy=%b want 0", busy); end
    endtask

    task automatic test_stop_on_full();
        stop_on_full = 1'b1;
        pulse_arm();
        bus.res_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.res_data = 32'h100 + 32'(i);
            tick();
        end
        bus.res_valid = 1'b0;
        tests++;
        if (count !== 5'd16 || overflow !== 1'b1 || busy !== 1'b0) begin
            failed++; $display("FAIL stop_full: got count=%0d ovf=%b busy=%b want 16 1 0", count, overflow, busy);
        end
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h1FF;
        tick();
        bus.res_valid = 1'b0;
        tests++;
        if (count !== 5'd16 || bus.rd_data !== 32'h100) begin
            failed++; $display("FAIL frozen_ignore: got count=%0d d=%h want 16 100", count, bus.rd_data);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_word;
        pulse_arm();
        tests++;
        if (count !== 5'd16 || overflow !== 1'b0 || busy !== 1'b1) begin
            failed++; $display("FAIL rearm: got count=%0d ovf=%b busy=%b want 16 0 1", count, overflow, busy);
        end
        bus.res_valid = 1'b1;
        bus.res_data  = 32'hAA;
        bus.rd_ready  = 1'b1;
        tick();
        bus.res_valid = 1'b0;
        bus.rd_ready  = 1'b0;
        tests++;
        if (count !== 5'd16 || overflow !== 1'b0 || bus.rd_data !== 32'h101) begin
            failed++; $display("FAIL full_pushpop: got count=%0d ovf=%b d=%h want 16 0 101", count, overflow, bus.rd_data);
        end
        pulse_disarm();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_word = (i < 15) ? 32'h101 + 32'(i) : 32'hAA;
            tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_word) begin
                failed++; $display("FAIL full_drain%0d: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp_word);
            end
            tick();
        end
        bus.rd_ready = 1'b0;
        tests++;
        if (count !== 5'd0 || bus.rd_valid !== 1'b0) begin
            failed++; $display("FAIL full_empty: got count=%0d v=%b want 0 0", count, bus.rd_valid);
        end
    endtask

    task automatic test_no_stop();
        stop_on_full = 1'b0;
        pulse_arm();
        bus.res_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.res_data = 32'h200 + 32'(i);
            tick();
        end
        bus.res_valid = 1'b0;
        tests++;
        if (count !== 5'd16 || overflow !== 1'b1 || busy !== 1'b1) begin
            failed++; $display("FAIL nostop_full: got count=%0d ovf=%b busy=%b want 16 1 1", count, overflow, busy);
        end
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (bus.rd_data !== 32'h200 + 32'(i)) begin
                failed++; $display("FAIL nostop_drain%0d: got %h want %h", i, bus.rd_data, 32'h200 + 32'(i));
            end
            tick();
        end
        bus.rd_ready = 1'b0;
        tests++;
        if (count !== 5'd0 || overflow !== 1'b1 || busy !== 1'b1) begin
            failed++; $display("FAIL nostop_after: got count=%0d ovf=%b busy=%b want 0 1 1", count, overflow, busy);
        end
        pulse_disarm();
    endtask

    task automatic test_back_to_back();
        pulse_arm();
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h300;
        tick();
        bus.rd_ready = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            bus.res_data = 32'h300 + 32'(i);
            tests++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h300 + 32'(i - 1) || count !== 5'd1) begin
                failed++; $display("FAIL b2b%0d: got v=%b d=%h c=%0d want v=1 d=%h c=1",
                                   i, bus.rd_valid, bus.rd_data, count, 32'h300 + 32'(i - 1));
            end
            tick();
        end
        bus.res_valid = 1'b0;
        bus.rd_ready  = 1'b0;
        tests++;
        if (count !== 5'd1 || bus.rd_data !== 32'h328) begin
            failed++; $display("FAIL b2b_tail: got count=%0d d=%h want 1 328", count, bus.rd_data);
        end
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        tests++;
        if (count !== 5'd0 || bus.rd_valid !== 1'b0) begin
            failed++; $display("FAIL b2b_empty: got count=%0d v=%b want 0 0", count, bus.rd_valid);
        end
        pulse_disarm();
    endtask

    task automatic test_reset_mid();
        pulse_arm();
        bus.res_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.res_data = 32'h400 + 32'(i);
            tick();
        end
        bus.res_valid = 1'b0;
        tests++;
        if (count !== 5'd5 || busy !== 1'b1) begin
            failed++; $display("FAIL mid_pre: got count=%0d busy=%b want 5 1", count, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (count !== 5'd0 || bus.rd_valid !== 1'b0 || busy !== 1'b0) begin
            failed++; $display("FAIL mid_async: got count=%0d v=%b busy=%b want 0 0 0", count, bus.rd_valid, busy);
        end
        #1;
        rst_n = 1'b1;
        tick();
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h4FF;
        tick();
        bus.res_valid = 1'b0;
        tests++;
        if (count !== 5'd0 || busy !== 1'b0) begin
            failed++; $display("FAIL mid_idle: got count=%0d busy=%b want 0 0", count, busy);
        end
    endtask

`ifdef WB_TRACE_TS_EN
    task automatic test_timestamp();
        pulse_arm();
        tick(); tick(); tick();
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h500;
        tick();
        bus.res_valid = 1'b0;
        tick(); tick(); tick();
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h501;
        tick();
        bus.res_valid = 1'b0;
        tests++;
        if (bus.rd_ts !== 16'd3 || bus.rd_data !== 32'h500) begin
            failed++; $display("FAIL ts_first: got ts=%0d d=%h want 3 500", bus.rd_ts, bus.rd_data);
        end
        bus.rd_ready = 1'b1;
        tick();
        tests++;
        if (bus.rd_ts !== 16'd7 || bus.rd_data !== 32'h501) begin
            failed++; $display("FAIL ts_second: got ts=%0d d=%h want 7 501", bus.rd_ts, bus.rd_data);
        end
        tick();
        bus.rd_ready = 1'b0;
        pulse_disarm();
    endtask
`endif

    initial begin
        tests         = 0;
        failed        = 0;
        rst_n         = 1'b0;
        arm           = 1'b0;
        disarm        = 1'b0;
        stop_on_full  = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.rd_ready  = 1'b0;
        #3;
        test_reset();
        #9;
        rst_n = 1'b1;
        tick();
        test_basic();
        test_stop_on_full();
        test_full_push_pop();
        test_no_stop();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_TRACE_TS_EN
        test_timestamp();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
